// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    // Converter control states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Digit code the segment decoder shows as a dark digit
    localparam logic [3:0] BCD_BLANK  = 4'hF;

    // Double-dabble correction: digits at or above the threshold get the offset
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage : bin2bcd_pkg

// File: rtl/bin2bcd_seq_if.sv
// start/busy/done handshake and data bus between a requester and bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);

    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    // Requester side
    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    // Converter side
    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );

endinterface : bin2bcd_seq_if

// File: rtl/bcd_digit_adj.sv
// One BCD digit corrector: values of five or more are offset by three so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_c_o
);

    // Conditional add-3; the 4-bit sum cannot exceed 4'hC for legal digits
    always_comb begin
        digit_c_o = digit_i;
        if (digit_i >= ADJ_THRESH) begin
            digit_c_o = digit_i + ADJ_ADD;
        end
    end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking is compiled in with BIN2BCD_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BIN_W + BCD_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             state_q;
    logic [SR_W-1:0]    sr_q;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_sticky_q;
    logic               ovf_sticky_d;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_d;
    logic [BCD_W-1:0]   bcd_wr;
    logic               ovf_q;

    // One column of digit correctors over the BCD part of the shift register
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i   (sr_q[BIN_W + 4*g +: 4]),
            .digit_c_o (sr_adj[BIN_W + 4*g +: 4])
        );
    end

    // Binary part passes through untouched; whole register then shifts left
    assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
    assign sr_d              = {sr_adj[SR_W-2:0], 1'b0};
    assign ovf_sticky_d      = ovf_sticky_q | sr_adj[SR_W-1];
    assign bcd_d             = sr_d[SR_W-1 -: BCD_W];

`ifdef BIN2BCD_BLANK_EN
    // Leading-zero blanking: scan from the top digit down, digit 0 never blanks
    always_comb begin
        logic lead;
        bcd_wr = bcd_d;
        lead   = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (lead && (bcd_d[4*i +: 4] == 4'd0)) begin
                bcd_wr[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign bcd_wr = bcd_d;
`endif

    // Control FSM, shift datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sr_q         <= {BCD_W'(0), bus.bin_in};
                        cnt_q        <= CNT_W'(BIN_W);
                        ovf_sticky_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q         <= sr_d;
                    cnt_q        <= cnt_q - CNT_W'(1);
                    ovf_sticky_q <= ovf_sticky_d;
                    // Last iteration: publish the result on this same edge
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= bcd_wr;
                        ovf_q   <= ovf_sticky_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq in three width/digit configurations.
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) b83 ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) b82 ();
    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) b165 ();

    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) u_83  (.clk(clk), .rst_n(rst_n), .bus(b83));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) u_82  (.clk(clk), .rst_n(rst_n), .bus(b82));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_165 (.clk(clk), .rst_n(rst_n), .bus(b165));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [11:0] EXP_059 = 12'hF59;
    localparam logic [11:0] EXP_007 = 12'hFF7;
    localparam logic [11:0] EXP_000 = 12'hFF0;
    localparam logic [11:0] EXP_042 = 12'hF42;
    localparam logic [7:0]  EXP_100 = 8'hF0;
`else
    localparam logic [11:0] EXP_059 = 12'h059;
    localparam logic [11:0] EXP_007 = 12'h007;
    localparam logic [11:0] EXP_000 = 12'h000;
    localparam logic [11:0] EXP_042 = 12'h042;
    localparam logic [7:0]  EXP_100 = 8'h00;
`endif

    task automatic test_reset;
        rst_n = 1'b0;
        b83.start = 1'b0;  b83.bin_in = '0;
        b82.start = 1'b0;  b82.bin_in = '0;
        b165.start = 1'b0; b165.bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b83.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", b83.busy); end
        checks++; if (b83.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", b83.done); end
        checks++; if (b83.bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h expected 000", b83.bcd_out); end
        checks++; if (b83.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", b83.overflow); end
        checks++; if (b165.busy !== 1'b0 || b165.bcd_out !== 20'h0) begin errors++; $display("FAIL reset_wide: got busy %b bcd %h expected 0/00000", b165.busy, b165.bcd_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_max255;
        int early;
        @(negedge clk);
        b83.bin_in = 8'd255; b83.start = 1'b1;
        @(posedge clk); #1;
        checks++; if (b83.busy !== 1'b1) begin errors++; $display("FAIL max255_busy_accept: got %b expected 1", b83.busy); end
        checks++; if (b83.done !== 1'b0) begin errors++; $display("FAIL max255_done_accept: got %b expected 0", b83.done); end
        @(negedge clk);
        b83.start = 1'b0; b83.bin_in = 8'd0;
        early = 0;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            if (b83.done === 1'b1 || b83.busy !== 1'b1) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL max255_early: got %0d bad cycles expected 0", early); end
        @(posedge clk); #1;
        checks++; if (b83.done !== 1'b1) begin errors++; $display("FAIL max255_done: got %b expected 1", b83.done); end
        checks++; if (b83.busy !== 1'b0) begin errors++; $display("FAIL max255_busy_end: got %b expected 0", b83.busy); end
        checks++; if (b83.bcd_out !== 12'h255) begin errors++; $display("FAIL max255_bcd: got %h expected 255", b83.bcd_out); end
        checks++; if (b83.overflow !== 1'b0) begin errors++; $display("FAIL max255_ovf: got %b expected 0", b83.overflow); end
        @(posedge clk); #1;
        checks++; if (b83.done !== 1'b0) begin errors++; $display("FAIL max255_done_pulse: got %b expected 0", b83.done); end
        checks++; if (b83.bcd_out !== 12'h255) begin errors++; $display("FAIL max255_hold: got %h expected 255", b83.bcd_out); end
    endtask

    task automatic test_overflow;
        // 100 does not fit in two digits
        @(negedge clk);
        b82.bin_in = 8'd100; b82.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b82.start = 1'b0;
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (b82.done !== 1'b1) begin errors++; $display("FAIL ovf100_done: got %b expected 1", b82.done); end
        checks++; if (b82.bcd_out !== EXP_100) begin errors++; $display("FAIL ovf100_bcd: got %h expected %h", b82.bcd_out, EXP_100); end
        checks++; if (b82.overflow !== 1'b1) begin errors++; $display("FAIL ovf100_flag: got %b expected 1", b82.overflow); end
        // 99 is the largest value that fits; sticky flag must clear
        @(negedge clk);
        b82.bin_in = 8'd99; b82.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b82.start = 1'b0;
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (b82.done !== 1'b1) begin errors++; $display("FAIL ovf99_done: got %b expected 1", b82.done); end
        checks++; if (b82.bcd_out !== 8'h99) begin errors++; $display("FAIL ovf99_bcd: got %h expected 99", b82.bcd_out); end
        checks++; if (b82.overflow !== 1'b0) begin errors++; $display("FAIL ovf99_flag: got %b expected 0", b82.overflow); end
        repeat (3) @(posedge clk); #1;
        checks++; if (b82.bcd_out !== 8'h99 || b82.overflow !== 1'b0) begin errors++; $display("FAIL ovf99_hold: got %h/%b expected 99/0", b82.bcd_out, b82.overflow); end
    endtask

    task automatic test_wide_ignore_start;
        int ndone;
        int done_k;
        logic [19:0] bcd_at_done;
        ndone = 0; done_k = -1; bcd_at_done = '0;
        @(negedge clk);
        b165.bin_in = 16'd65535; b165.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b165.start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (b165.done === 1'b1) begin
                ndone++;
                done_k = k;
                bcd_at_done = b165.bcd_out;
            end
            if (k == 4) begin
                @(negedge clk);
                b165.start = 1'b1; b165.bin_in = 16'd1;
            end
            if (k == 5) begin
                @(negedge clk);
                b165.start = 1'b0; b165.bin_in = 16'd0;
            end
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL wide_done_count: got %0d expected 1", ndone); end
        checks++; if (done_k !== 16) begin errors++; $display("FAIL wide_latency: got edge %0d expected 16", done_k); end
        checks++; if (bcd_at_done !== 20'h65535) begin errors++; $display("FAIL wide_bcd: got %h expected 65535", bcd_at_done); end
        checks++; if (b165.overflow !== 1'b0 || b165.busy !== 1'b0) begin errors++; $display("FAIL wide_end: got ovf %b busy %b expected 0/0", b165.overflow, b165.busy); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        b83.bin_in = 8'd59; b83.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b83.bin_in = 8'd7;
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (b83.done !== 1'b1 || b83.bcd_out !== EXP_059) begin errors++; $display("FAIL b2b_59: got done %b bcd %h expected 1/%h", b83.done, b83.bcd_out, EXP_059); end
        @(posedge clk); #1;
        checks++; if (b83.busy !== 1'b1 || b83.done !== 1'b0) begin errors++; $display("FAIL b2b_accept7: got busy %b done %b expected 1/0", b83.busy, b83.done); end
        @(negedge clk);
        b83.bin_in = 8'd0;
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (b83.done !== 1'b1 || b83.bcd_out !== EXP_007) begin errors++; $display("FAIL b2b_7: got done %b bcd %h expected 1/%h", b83.done, b83.bcd_out, EXP_007); end
        @(posedge clk); #1;
        checks++; if (b83.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept0: got busy %b expected 1", b83.busy); end
        @(negedge clk);
        b83.start = 1'b0;
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (b83.done !== 1'b1 || b83.bcd_out !== EXP_000) begin errors++; $display("FAIL b2b_0: got done %b bcd %h expected 1/%h", b83.done, b83.bcd_out, EXP_000); end
    endtask

    task automatic test_reset_abort;
        int ndone;
        @(negedge clk);
        b83.bin_in = 8'd123; b83.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b83.start = 1'b0;
        repeat (8) @(posedge clk); #1;
        checks++; if (b83.bcd_out !== 12'h123) begin errors++; $display("FAIL abort_pre: got %h expected 123", b83.bcd_out); end
        @(negedge clk);
        b83.bin_in = 8'd200; b83.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b83.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (b83.busy !== 1'b0 || b83.done !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got busy %b done %b expected 0/0", b83.busy, b83.done); end
        checks++; if (b83.bcd_out !== 12'h000 || b83.overflow !== 1'b0) begin errors++; $display("FAIL abort_data: got %h/%b expected 000/0", b83.bcd_out, b83.overflow); end
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (b83.done === 1'b1) ndone++;
            if (k == 1) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        checks++; if (ndone !== 0 || b83.busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %0d dones busy %b expected 0/0", ndone, b83.busy); end
        @(negedge clk);
        b83.bin_in = 8'd42; b83.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b83.start = 1'b0;
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        checks++; if (b83.done !== 1'b1 || b83.bcd_out !== EXP_042) begin errors++; $display("FAIL abort_42: got done %b bcd %h expected 1/%h", b83.done, b83.bcd_out, EXP_042); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_max255();
        test_overflow();
        test_wide_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bin2bcd_seq
